ccu_coherence_arbiter: RTL and testbench

Cache coherence unit (CCU) that sits directly downstream of the per-core L1 cache controllers. It accepts miss and write-upgrade requests from up to NUM_CORES L1s and arbitrates them round-robin. For the granted request it broadcasts a snoop to every other L1, collects the snoop responses, writes back modified data if needed, and fetches from memory when no cache holds the line. It then returns the 32-bit word and the new MESI state to the requester.

---
 rtl/ccu_coherence_arbiter_if.sv | 45 ++++
 rtl/ccu_coherence_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_ccu_coherence_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ccu_coherence_arbiter_if.sv
// rtl/ccu_coherence_arbiter_if.sv - L1 request, snoop and memory signal bundle for the coherence arbiter
interface ccu_coherence_arbiter_if #(
    parameter int NUM_CORES = 4
);
    logic [NUM_CORES-1:0]    req;
    logic [NUM_CORES-1:0]    req_rd;
    logic [NUM_CORES-1:0]    req_wr;
    logic [32*NUM_CORES-1:0] req_addr;
    logic [32*NUM_CORES-1:0] req_data;
    logic [NUM_CORES-1:0]    bs_req;
    logic [31:0]             snoop_address;
    logic [1:0]              snoop_upd_state;
    logic [NUM_CORES-1:0]    snoop_valid;
    logic [NUM_CORES-1:0]    snoop_hit;
    logic [2*NUM_CORES-1:0]  snoop_state;
    logic [32*NUM_CORES-1:0] snoop_data;
    logic [NUM_CORES-1:0]    CCU_ready;
    logic [31:0]             data_out_CCU;
    logic [1:0]              cache_upd_state_core;
    logic                    mem_req;
    logic                    mem_wr;
    logic [31:0]             mem_addr;
    logic [31:0]             mem_wdata;
    logic                    mem_ready;
    logic [31:0]             mem_rdata;
    logic                    busy;

    modport slave (
        input  req, req_rd, req_wr, req_addr, req_data,
        input  snoop_valid, snoop_hit, snoop_state, snoop_data,
        input  mem_ready, mem_rdata,
        output bs_req, snoop_address, snoop_upd_state,
        output CCU_ready, data_out_CCU, cache_upd_state_core,
        output mem_req, mem_wr, mem_addr, mem_wdata, busy
    );

    modport master (
        output req, req_rd, req_wr, req_addr, req_data,
        output snoop_valid, snoop_hit, snoop_state, snoop_data,
        output mem_ready, mem_rdata,
        input  bs_req, snoop_address, snoop_upd_state,
        input  CCU_ready, data_out_CCU, cache_upd_state_core,
        input  mem_req, mem_wr, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/ccu_coherence_arbiter.sv
// rtl/ccu_coherence_arbiter.sv - round-robin MESI snoop arbiter with writeback and memory fill
module ccu_coherence_arbiter #(
    parameter int NUM_CORES     = 4,
    parameter int SNOOP_TIMEOUT = 16
) (
    input logic                    clk,
    input logic                    rst,
    ccu_coherence_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_CORES);
    localparam int TW = $clog2(SNOOP_TIMEOUT + 1);
    localparam logic [1:0] ST_M = 2'b00, ST_E = 2'b01, ST_S = 2'b10, ST_I = 2'b11;

    typedef enum logic [2:0] {IDLE, SNOOP, COLLECT, MEM_WB, MEM_RD, RESPOND} state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]           gnt_q, gnt_d;
    logic                    rd_q, rd_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [NUM_CORES-1:0]    resp_q, resp_d;
    logic [NUM_CORES-1:0]    hit_q, hit_d;
    logic [2*NUM_CORES-1:0]  rstate_q, rstate_d;
    logic [32*NUM_CORES-1:0] rdata_q, rdata_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [31:0]             ret_data_q, ret_data_d;
    logic [1:0]              ret_state_q, ret_state_d;

    logic [NUM_CORES-1:0]    bs_req_q, bs_req_d;
    logic [NUM_CORES-1:0]    ccu_ready_q, ccu_ready_d;
    logic [31:0]             snoop_address_q, snoop_address_d;
    logic [1:0]              snoop_upd_state_q, snoop_upd_state_d;
    logic [31:0]             data_out_q, data_out_d;
    logic [1:0]              upd_state_q, upd_state_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_wr_q, mem_wr_d;
    logic [31:0]             mem_addr_q, mem_addr_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    busy_q, busy_d;

    logic                    gnt_found;
    logic [IW-1:0]           gnt_idx;
    logic                    own_found;
    logic                    own_m;
    logic [IW-1:0]           own_idx;
    logic [31:0]             own_word;
    logic [NUM_CORES-1:0]    gnt_onehot;
    logic                    collect_done;

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!gnt_found && bus.req[(int'(rr_ptr_q) + k) % NUM_CORES]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'((int'(rr_ptr_q) + k) % NUM_CORES);
            end
        end
    end

    // Owner is the lowest hitting core, but any M holder wins since it has the only valid copy.
    always_comb begin
        own_found = 1'b0;
        own_m     = 1'b0;
        own_idx   = '0;
        for (int j = 0; j < NUM_CORES; j++) begin
            if (resp_q[j] && hit_q[j]) begin
                if (rstate_q[2*j +: 2] == ST_M && !own_m) begin
                    own_idx   = IW'(j);
                    own_m     = 1'b1;
                    own_found = 1'b1;
                end else if (!own_found) begin
                    own_idx   = IW'(j);
                    own_found = 1'b1;
                end
            end
        end
        own_word = rdata_q[32*own_idx +: 32];
    end

    assign gnt_onehot   = NUM_CORES'(1) << gnt_q;
    assign collect_done = (&(resp_q | gnt_onehot)) || (timer_q == TW'(SNOOP_TIMEOUT));

    always_comb begin
        state_d           = state_q;
        rr_ptr_d          = rr_ptr_q;
        gnt_d             = gnt_q;
        rd_d              = rd_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        resp_d            = resp_q;
        hit_d             = hit_q;
        rstate_d          = rstate_q;
        rdata_d           = rdata_q;
        timer_d           = timer_q;
        ret_data_d        = ret_data_q;
        ret_state_d       = ret_state_q;
        bs_req_d          = '0;
        ccu_ready_d       = '0;
        snoop_address_d   = snoop_address_q;
        snoop_upd_state_d = snoop_upd_state_q;
        data_out_d        = data_out_q;
        upd_state_d       = upd_state_q;
        mem_req_d         = mem_req_q;
        mem_wr_d          = mem_wr_q;
        mem_addr_d        = mem_addr_q;
        mem_wdata_d       = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    gnt_d             = gnt_idx;
                    rd_d              = bus.req_rd[gnt_idx] | ~bus.req_wr[gnt_idx];
                    addr_d            = bus.req_addr[32*gnt_idx +: 32];
                    wdata_d           = bus.req_data[32*gnt_idx +: 32];
                    rr_ptr_d          = (gnt_idx == IW'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
                    bs_req_d          = ~(NUM_CORES'(1) << gnt_idx);
                    snoop_address_d   = bus.req_addr[32*gnt_idx +: 32];
                    snoop_upd_state_d = rd_d ? ST_S : ST_I;
                    state_d           = SNOOP;
                end
            end
            SNOOP: begin
                resp_d  = '0;
                hit_d   = '0;
                timer_d = '0;
                state_d = COLLECT;
            end
            COLLECT: begin
                for (int j = 0; j < NUM_CORES; j++) begin
                    if (bus.snoop_valid[j] && IW'(j) != gnt_q) begin
                        resp_d[j]           = 1'b1;
                        hit_d[j]            = bus.snoop_hit[j];
                        rstate_d[2*j +: 2]  = bus.snoop_state[2*j +: 2];
                        rdata_d[32*j +: 32] = bus.snoop_data[32*j +: 32];
                    end
                end
                timer_d = timer_q + 1'b1;
                if (collect_done) begin
                    if (own_m) begin
                        state_d     = MEM_WB;
                        mem_req_d   = 1'b1;
                        mem_wr_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = own_word;
                        ret_data_d  = rd_q ? own_word : wdata_q;
                        ret_state_d = rd_q ? ST_S : ST_M;
                    end else if (rd_q && !own_found) begin
                        state_d    = MEM_RD;
                        mem_req_d  = 1'b1;
                        mem_wr_d   = 1'b0;
                        mem_addr_d = addr_q;
                    end else begin
                        state_d     = RESPOND;
                        ccu_ready_d = gnt_onehot;
                        data_out_d  = rd_q ? own_word : wdata_q;
                        upd_state_d = rd_q ? ST_S : ST_M;
                    end
                end
            end
            MEM_WB: begin
                if (bus.mem_ready) begin
                    mem_req_d   = 1'b0;
                    mem_wr_d    = 1'b0;
                    state_d     = RESPOND;
                    ccu_ready_d = gnt_onehot;
                    data_out_d  = ret_data_q;
                    upd_state_d = ret_state_q;
                end
            end
            MEM_RD: begin
                if (bus.mem_ready) begin
                    mem_req_d   = 1'b0;
                    state_d     = RESPOND;
                    ccu_ready_d = gnt_onehot;
                    data_out_d  = bus.mem_rdata;
                    upd_state_d = ST_E;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= IDLE;
            rr_ptr_q          <= '0;
            gnt_q             <= '0;
            rd_q              <= 1'b0;
            addr_q            <= '0;
            wdata_q           <= '0;
            resp_q            <= '0;
            hit_q             <= '0;
            rstate_q          <= '1;
            rdata_q           <= '0;
            timer_q           <= '0;
            ret_data_q        <= '0;
            ret_state_q       <= ST_I;
            bs_req_q          <= '0;
            ccu_ready_q       <= '0;
            snoop_address_q   <= '0;
            snoop_upd_state_q <= ST_I;
            data_out_q        <= '0;
            upd_state_q       <= ST_I;
            mem_req_q         <= 1'b0;
            mem_wr_q          <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            busy_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            rr_ptr_q          <= rr_ptr_d;
            gnt_q             <= gnt_d;
            rd_q              <= rd_d;
            addr_q            <= addr_d;
            wdata_q           <= wdata_d;
            resp_q            <= resp_d;
            hit_q             <= hit_d;
            rstate_q          <= rstate_d;
            rdata_q           <= rdata_d;
            timer_q           <= timer_d;
            ret_data_q        <= ret_data_d;
            ret_state_q       <= ret_state_d;
            bs_req_q          <= bs_req_d;
            ccu_ready_q       <= ccu_ready_d;
            snoop_address_q   <= snoop_address_d;
            snoop_upd_state_q <= snoop_upd_state_d;
            data_out_q        <= data_out_d;
            upd_state_q       <= upd_state_d;
            mem_req_q         <= mem_req_d;
            mem_wr_q          <= mem_wr_d;
            mem_addr_q        <= mem_addr_d;
            mem_wdata_q       <= mem_wdata_d;
            busy_q            <= busy_d;
        end
    end

    assign bus.bs_req               = bs_req_q;
    assign bus.snoop_address        = snoop_address_q;
    assign bus.snoop_upd_state      = snoop_upd_state_q;
    assign bus.CCU_ready            = ccu_ready_q;
    assign bus.data_out_CCU         = data_out_q;
    assign bus.cache_upd_state_core = upd_state_q;
    assign bus.mem_req              = mem_req_q;
    assign bus.mem_wr               = mem_wr_q;
    assign bus.mem_addr             = mem_addr_q;
    assign bus.mem_wdata            = mem_wdata_q;
    assign bus.busy                 = busy_q;
endmodule

// File: tb/tb_ccu_coherence_arbiter.sv
// tb/tb_ccu_coherence_arbiter.sv - directed self-checking bench for the coherence arbiter
module tb_ccu_coherence_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lat;
    int   ready_count = 0;
    int   mem_req_cycles = 0;
    int   mem_cnt = 0;
    int   mem_lat = 3;
    bit   mem_hold = 1'b0;
    int   rc0;
    int   mq0;
    int   g;
    int   exp_order [5];
    logic [3:0] oh;
    logic [3:0] nb;

    ccu_coherence_arbiter_if #(.NUM_CORES(4)) ifc ();

    ccu_coherence_arbiter #(.NUM_CORES(4), .SNOOP_TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: mem_ready on the mem_lat-th cycle that mem_req is seen high.
    always @(negedge clk) begin
        if (ifc.CCU_ready != '0) ready_count++;
        if (ifc.mem_req) begin
            mem_req_cycles++;
            mem_cnt++;
            ifc.mem_ready = (mem_cnt == mem_lat) && !mem_hold;
        end else begin
            mem_cnt       = 0;
            ifc.mem_ready = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int k, input bit rd, input logic [31:0] addr, input logic [31:0] data);
        ifc.req[k]             = 1'b1;
        ifc.req_rd[k]          = rd;
        ifc.req_wr[k]          = !rd;
        ifc.req_addr[32*k +: 32] = addr;
        ifc.req_data[32*k +: 32] = data;
    endtask

    task automatic snoop(input logic [3:0] v, input logic [3:0] h, input logic [7:0] st, input logic [127:0] d);
        ifc.snoop_valid = v;
        ifc.snoop_hit   = h;
        ifc.snoop_state = st;
        ifc.snoop_data  = d;
    endtask

    task automatic wait_ready(input int max, output int c);
        while (ifc.CCU_ready == '0 && cyc < max) step();
        c = cyc;
    endtask

    initial begin
        ifc.req = '0; ifc.req_rd = '0; ifc.req_wr = '0; ifc.req_addr = '0; ifc.req_data = '0;
        snoop(4'h0, 4'h0, 8'hFF, 128'h0);
        ifc.mem_rdata = '0;
        rst = 1'b0;
        step(); step();
        chk("reset_strobes", {ifc.bs_req, ifc.CCU_ready, ifc.mem_req, ifc.mem_wr, ifc.busy}, 64'h0);
        chk("reset_addrs", {ifc.snoop_address, ifc.mem_addr}, 64'h0);
        chk("reset_data", {ifc.mem_wdata, ifc.data_out_CCU}, 64'h0);
        chk("reset_states", {ifc.snoop_upd_state, ifc.cache_upd_state_core}, 64'hF);
        rst = 1'b1;
        step();

        // Core0 read miss everywhere, memory fill after 3 cycles
        ifc.mem_rdata = 32'hDEAD_BEEF;
        issue(0, 1'b1, 32'h0000_1040, 32'h0);
        cyc = 0;
        step();
        chk("t1_bs_req", ifc.bs_req, 4'b1110);
        chk("t1_snoop_addr", ifc.snoop_address, 32'h0000_1040);
        chk("t1_snoop_upd", ifc.snoop_upd_state, 2'b10);
        chk("t1_busy", ifc.busy, 1'b1);
        step(); snoop(4'b1110, 4'b0000, 8'hFF, 128'h0);
        step(); snoop(4'b0000, 4'b0000, 8'hFF, 128'h0);
        step();
        chk("t1_mem_rd", {ifc.mem_req, ifc.mem_wr, ifc.mem_addr}, {1'b1, 1'b0, 32'h0000_1040});
        wait_ready(30, lat);
        chk("t1_latency", lat, 7);
        chk("t1_ready", ifc.CCU_ready, 4'b0001);
        chk("t1_data", ifc.data_out_CCU, 32'hDEAD_BEEF);
        chk("t1_state", ifc.cache_upd_state_core, 2'b01);
        ifc.req[0] = 1'b0;

        // Core1 read, core2 holds the line in M: writeback then S
        step();
        issue(1, 1'b1, 32'h2000_0080, 32'h0);
        cyc = 0;
        step();
        chk("t2_bs_req", ifc.bs_req, 4'b1101);
        chk("t2_snoop_upd", ifc.snoop_upd_state, 2'b10);
        step(); snoop(4'b1101, 4'b0100, 8'hCF, {32'h0, 32'h1234_5678, 32'h0, 32'h0});
        step(); snoop(4'b0000, 4'b0000, 8'hFF, 128'h0);
        step();
        chk("t2_mem_wb", {ifc.mem_req, ifc.mem_wr, ifc.mem_addr}, {1'b1, 1'b1, 32'h2000_0080});
        chk("t2_mem_wdata", ifc.mem_wdata, 32'h1234_5678);
        wait_ready(30, lat);
        chk("t2_latency", lat, 7);
        chk("t2_ready", ifc.CCU_ready, 4'b0010);
        chk("t2_data", ifc.data_out_CCU, 32'h1234_5678);
        chk("t2_state", ifc.cache_upd_state_core, 2'b10);
        ifc.req[1] = 1'b0;

        // Core3 write, cores 0/1 share the line: invalidate, no memory, done in cycle 4
        step();
        issue(3, 1'b0, 32'h4000_0100, 32'hA5A5_A5A5);
        mq0 = mem_req_cycles;
        cyc = 0;
        step();
        chk("t3_bs_req", ifc.bs_req, 4'b0111);
        chk("t3_snoop_upd", ifc.snoop_upd_state, 2'b11);
        step(); snoop(4'b0111, 4'b0011, 8'hFA, {32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222});
        step(); snoop(4'b0000, 4'b0000, 8'hFF, 128'h0);
        step();
        chk("t3_ready_cycle4", ifc.CCU_ready, 4'b1000);
        chk("t3_data", ifc.data_out_CCU, 32'hA5A5_A5A5);
        chk("t3_state", ifc.cache_upd_state_core, 2'b00);
        chk("t3_no_mem_req", mem_req_cycles - mq0, 0);

        // All four cores request writes continuously: grants rotate 0,1,2,3,0
        for (int k = 0; k < 4; k++) issue(k, 1'b0, 32'h6000_0000 + 32'(k * 4), 32'hC0DE_0000 + 32'(k));
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
        rc0 = ready_count;
        for (int t = 0; t < 5; t++) begin
            g  = exp_order[t];
            oh = 4'(1 << g);
            nb = ~oh;
            step();
            step();
            chk("t4_bs_req", ifc.bs_req, nb);
            step(); snoop(4'b1111, 4'b0000, 8'hFF, 128'h0);
            step(); snoop(4'b0000, 4'b0000, 8'hFF, 128'h0);
            chk("t4_no_early_ready", ifc.CCU_ready, 4'b0000);
            step();
            chk("t4_ready", ifc.CCU_ready, oh);
            chk("t4_data", ifc.data_out_CCU, 32'hC0DE_0000 + 32'(g));
        end
        ifc.req = '0;
        step();
        chk("t4_ready_count", ready_count - rc0, 5);

        // Core0 write; core2 stays silent (its hit/M lines are ignored) so COLLECT times out
        issue(0, 1'b0, 32'h5000_0000, 32'h0BAD_F00D);
        mq0 = mem_req_cycles;
        cyc = 0;
        step();
        chk("t5_bs_req", ifc.bs_req, 4'b1110);
        step(); snoop(4'b1010, 4'b0100, 8'hCF, {32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0});
        step(); snoop(4'b0000, 4'b0100, 8'hCF, {32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0});
        wait_ready(40, lat);
        chk("t5_latency", lat, 19);
        chk("t5_ready", ifc.CCU_ready, 4'b0001);
        chk("t5_data", ifc.data_out_CCU, 32'h0BAD_F00D);
        chk("t5_state", ifc.cache_upd_state_core, 2'b00);
        chk("t5_no_mem_req", mem_req_cycles - mq0, 0);
        ifc.req[0] = 1'b0;
        snoop(4'b0000, 4'b0000, 8'hFF, 128'h0);

        // Core1 read miss; reset lands while waiting on memory, then the request is re-granted
        step();
        issue(1, 1'b1, 32'h3000_0004, 32'h0);
        mem_hold = 1'b1;
        ifc.mem_rdata = 32'h600D_CAFE;
        rc0 = ready_count;
        cyc = 0;
        step();
        step(); snoop(4'b1101, 4'b0000, 8'hFF, 128'h0);
        step(); snoop(4'b0000, 4'b0000, 8'hFF, 128'h0);
        step();
        chk("t6_mem_rd", {ifc.mem_req, ifc.mem_wr, ifc.mem_addr}, {1'b1, 1'b0, 32'h3000_0004});
        rst = 1'b0;
        step();
        chk("t6_reset_abort", {ifc.mem_req, ifc.busy, ifc.CCU_ready}, 64'h0);
        rst = 1'b1;
        mem_hold = 1'b0;
        cyc = 0;
        step();
        chk("t6_regrant", ifc.bs_req, 4'b1101);
        step(); snoop(4'b1101, 4'b0000, 8'hFF, 128'h0);
        step(); snoop(4'b0000, 4'b0000, 8'hFF, 128'h0);
        wait_ready(30, lat);
        chk("t6_latency", lat, 7);
        chk("t6_ready", ifc.CCU_ready, 4'b0010);
        chk("t6_data", ifc.data_out_CCU, 32'h600D_CAFE);
        chk("t6_state", ifc.cache_upd_state_core, 2'b01);
        chk("t6_ready_count", ready_count - rc0, 1);
        ifc.req[1] = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
